// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the banked SRAM vector movers.
// Holds bank geometry, standard vector lengths and the transfer FSM states.
package nn_pkg;

    localparam int NUM_BANKS = 64;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 12;
    localparam int LEN_W     = 10;
    localparam int SEL_W     = $clog2(NUM_BANKS);

    localparam int IMG_LEN = 784;
    localparam int HID_LEN = 200;
    localparam int OUT_LEN = 10;

    // Shared with the writer so both movers decode states identically.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } xfer_state_t;

endpackage

// File: rtl/bank_row_mux.sv
// Row buffer holding one word per bank, with a word select on the captured row.
// Ports: clk, capture (load rdata), rdata (all banks), sel (bank index), word.
module bank_row_mux
    import nn_pkg::*;
(
    input  logic                        clk,
    input  logic                        capture,
    input  logic [NUM_BANKS*DATA_W-1:0] rdata,
    input  logic [SEL_W-1:0]            sel,
    output logic [DATA_W-1:0]           word
);

    // Contents are don't-care until the first capture, so no reset.
    logic [DATA_W-1:0] row_buf [NUM_BANKS];

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                row_buf[b] <= rdata[b*DATA_W +: DATA_W];
            end
        end
    end

    assign word = row_buf[sel];

endmodule

// File: rtl/banked_vector_reader.sv
// Streams a linear vector out of interleaved SRAM banks (word n: bank n%64,
// row base+n/64) as an in-order valid/ready stream with index and last flag.
// Ports: CLK, Reset (sync, active high), start/base_addr/length request,
//        bank_en/bank_addr/bank_rdata SRAM side, out_* stream, busy, done.
module banked_vector_reader
    import nn_pkg::*;
(
    input  logic                        CLK,
    input  logic                        Reset,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [LEN_W-1:0]            length,
    output logic                        bank_en,
    output logic [ADDR_W-1:0]           bank_addr,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [LEN_W-1:0]            out_index,
    output logic                        busy,
    output logic                        done
);

    xfer_state_t       state;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] row;
    logic [DATA_W-1:0] word;
    logic              is_last;
    logic              row_end;

    assign is_last   = (cnt == len - LEN_W'(1));
    assign row_end   = &cnt[SEL_W-1:0];
    assign bank_addr = row;
    assign out_index = cnt;
    assign out_last  = out_valid & is_last;
    // Gate the data so it reads zero whenever nothing is offered.
    assign out_data  = out_valid ? word : '0;

    bank_row_mux u_row_mux (
        .clk     (CLK),
        .capture (state == ST_WAIT),
        .rdata   (bank_rdata),
        .sel     (cnt[SEL_W-1:0]),
        .word    (word)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            len       <= '0;
            row       <= '0;
            bank_en   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            bank_en <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        len  <= length;
                        cnt  <= '0;
                        row  <= base_addr;
                        busy <= 1'b1;
                        if (length != '0) begin
                            state   <= ST_READ;
                            bank_en <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    state     <= ST_STREAM;
                    out_valid <= 1'b1;
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        if (is_last) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                            // Last bank of this row consumed: fetch next row.
                            if (row_end) begin
                                row       <= row + ADDR_W'(1);
                                state     <= ST_READ;
                                bank_en   <= 1'b1;
                                out_valid <= 1'b0;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_banked_vector_reader.sv
// Directed bench for banked_vector_reader with a bank memory model and a
// queue of expected stream words checked at every handshake.
module tb_banked_vector_reader;
    import nn_pkg::*;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [LEN_W-1:0]  i;
        logic              l;
    } exp_t;

    logic                        CLK = 1'b0;
    logic                        Reset = 1'b1;
    logic                        start = 1'b0;
    logic [ADDR_W-1:0]           base_addr = '0;
    logic [LEN_W-1:0]            length = '0;
    logic                        bank_en;
    logic [ADDR_W-1:0]           bank_addr;
    logic [NUM_BANKS*DATA_W-1:0] bank_rdata = '0;
    logic [DATA_W-1:0]           out_data;
    logic                        out_valid;
    logic                        out_ready = 1'b1;
    logic                        out_last;
    logic [LEN_W-1:0]            out_index;
    logic                        busy;
    logic                        done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_e = 0;
    int en_cnt, done_cnt, done_cyc, valid_cnt, first_valid, hs_cnt, stall_cnt;
    int addr_log[$];
    exp_t sb[$];

    bit stalled = 1'b0;
    logic [DATA_W-1:0] h_d;
    logic [LEN_W-1:0]  h_i;
    logic              h_l;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    banked_vector_reader dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .bank_en    (bank_en),
        .bank_addr  (bank_addr),
        .bank_rdata (bank_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_index  (out_index),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DATA_W-1:0] mem_word(int b, int r);
        return DATA_W'(r * NUM_BANKS + b);
    endfunction

    // Bank model: one-cycle read latency.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (bank_en) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_rdata[b*DATA_W +: DATA_W] <= mem_word(b, int'(bank_addr));
            end
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (Reset) begin
            stalled = 1'b0;
        end else begin
            if (bank_en) begin
                en_cnt++;
                addr_log.push_back(int'(bank_addr));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (stalled) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(h_d));
                chk("hold_index", 32'(out_index), 32'(h_i));
                chk("hold_last", 32'(out_last), 32'(h_l));
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                chk("word_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data", 32'(out_data), 32'(e.d));
                    chk("index", 32'(out_index), 32'(e.i));
                    chk("last", 32'(out_last), 32'(e.l));
                end
            end
            stalled = out_valid && !out_ready;
            if (stalled) stall_cnt++;
            h_d = out_data;
            h_i = out_index;
            h_l = out_last;
        end
    end

    task automatic clear();
        en_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        valid_cnt = 0;
        first_valid = -1;
        hs_cnt = 0;
        stall_cnt = 0;
        addr_log.delete();
        sb.delete();
    endtask

    task automatic push_expected(int base, int len);
        for (int n = 0; n < len; n++) begin
            exp_t e;
            e.d = mem_word(n % NUM_BANKS, (base + n / NUM_BANKS) % (1 << ADDR_W));
            e.i = LEN_W'(n);
            e.l = (n == len - 1);
            sb.push_back(e);
        end
    endtask

    task automatic do_start(int base, int len);
        @(posedge CLK); #1;
        base_addr = ADDR_W'(base);
        length = LEN_W'(len);
        start = 1'b1;
        @(posedge CLK); #1;
        start_e = cyc;
        start = 1'b0;
    endtask

    task automatic run(int maxc, bit bp);
        int i = 0;
        while (done_cnt == 0 && i < maxc) begin
            @(posedge CLK); #1;
            i++;
            out_ready = bp ? pat[cyc % 4] : 1'b1;
            @(negedge CLK);
        end
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
        @(posedge CLK); #1;
        out_ready = 1'b1;
    endtask

    initial begin
        bit found;
        int dc;
        clear();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_bank_en", 32'(bank_en), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        Reset = 1'b0;

        // Full image
        clear();
        push_expected(0, IMG_LEN);
        do_start(0, IMG_LEN);
        run(2000, 1'b0);
        chk("img_bank_en", 32'(en_cnt), 32'd13);
        chk("img_latency", 32'(first_valid - start_e), 32'd2);
        chk("img_done_cyc", 32'(done_cyc - start_e), 32'd810);
        chk("img_words", 32'(hs_cnt), 32'(IMG_LEN));
        chk("img_left", 32'(sb.size()), 32'd0);
        chk("img_done_cnt", 32'(done_cnt), 32'd1);

        // Short vector, partial row
        clear();
        push_expected(5, OUT_LEN);
        do_start(5, OUT_LEN);
        run(100, 1'b0);
        chk("short_bank_en", 32'(en_cnt), 32'd1);
        chk("short_addr", 32'(addr_log.size() > 0 ? addr_log[0] : -1), 32'd5);
        chk("short_latency", 32'(first_valid - start_e), 32'd2);
        chk("short_words", 32'(hs_cnt), 32'd10);
        chk("short_left", 32'(sb.size()), 32'd0);

        // Backpressure
        clear();
        push_expected(2, 70);
        do_start(2, 70);
        run(500, 1'b1);
        chk("bp_bank_en", 32'(en_cnt), 32'd2);
        chk("bp_row2", 32'(addr_log.size() > 1 ? addr_log[1] : -1), 32'd3);
        chk("bp_stalls", 32'(stall_cnt > 0), 32'd1);
        chk("bp_words", 32'(hs_cnt), 32'd70);
        chk("bp_left", 32'(sb.size()), 32'd0);

        // Zero length
        clear();
        do_start(7, 0);
        run(10, 1'b0);
        chk("zero_bank_en", 32'(en_cnt), 32'd0);
        chk("zero_done_cyc", 32'(done_cyc - start_e), 32'd0);
        chk("zero_valid", 32'(valid_cnt), 32'd0);

        // Start while busy, then reset mid-stream at index 100
        clear();
        push_expected(0, HID_LEN);
        do_start(0, HID_LEN);
        @(posedge CLK); #1;
        base_addr = ADDR_W'(9);
        length = LEN_W'(3);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge CLK); #1;
            if (out_valid && out_index == LEN_W'(100)) found = 1'b1;
        end
        chk("rst_reached_100", 32'(found), 32'd1);
        Reset = 1'b1;
        @(posedge CLK); #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_index", 32'(out_index), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        chk("mid_rst_bank_en", 32'(bank_en), 32'd0);
        chk("mid_rst_addr", 32'(bank_addr), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        Reset = 1'b0;
        chk("mid_rst_words", 32'(hs_cnt), 32'd100);
        chk("busy_start_ignored", 32'(en_cnt), 32'd2);
        dc = done_cnt;
        repeat (4) @(posedge CLK);
        #1;
        chk("mid_rst_no_done", 32'(done_cnt), 32'(dc));

        // Fresh transfer after reset
        clear();
        push_expected(0, 70);
        do_start(0, 70);
        run(300, 1'b0);
        chk("fresh_words", 32'(hs_cnt), 32'd70);
        chk("fresh_left", 32'(sb.size()), 32'd0);

        // Row address wrap
        clear();
        push_expected(4095, 128);
        do_start(4095, 128);
        run(400, 1'b0);
        chk("wrap_bank_en", 32'(en_cnt), 32'd2);
        chk("wrap_row0", 32'(addr_log.size() > 0 ? addr_log[0] : -1), 32'd4095);
        chk("wrap_row1", 32'(addr_log.size() > 1 ? addr_log[1] : -1), 32'd0);
        chk("wrap_words", 32'(hs_cnt), 32'd128);
        chk("wrap_left", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
